// File: rtl/addr_map_pkg.sv
// Shared address-map constants and the translation result bundle.
// Default map: 1 MiB ROM at 0x0, 8 MiB RAM at 0x0020_0000.
package addr_map_pkg;

    localparam logic [31:0] ROM_BASE_DEF = 32'h0000_0000;
    localparam logic [31:0] ROM_SIZE_DEF = 32'h0010_0000;
    localparam logic [31:0] RAM_BASE_DEF = 32'h0020_0000;
    localparam logic [31:0] RAM_SIZE_DEF = 32'h0080_0000;

    typedef struct packed {
        logic [31:0] offset;
        logic        is_rom;
        logic        is_ram;
        logic        fault;
    } trans_t;

endpackage

// File: rtl/addr_region_match.sv
// Region hit/offset for one [base, base+size) window.
// No end address is formed, so the upper bound cannot wrap.
module addr_region_match (
    input  logic [31:0] addr,
    input  logic [31:0] base,
    input  logic [31:0] size,
    output logic        hit,
    output logic [31:0] offset
);

    logic [32:0] diff;

    // Bit 32 is the borrow: set when addr is below base.
    assign diff   = {1'b0, addr} - {1'b0, base};
    assign hit    = !diff[32] && ({1'b0, diff[31:0]} < {1'b0, size});
    assign offset = diff[31:0];

endmodule

// File: rtl/addr_trans.sv
// One-cycle ROM/RAM address translator with fault flag.
// ROM wins if the two windows overlap.
module addr_trans
    import addr_map_pkg::*;
#(
    parameter logic [31:0] ROM_BASE = ROM_BASE_DEF,
    parameter logic [31:0] ROM_SIZE = ROM_SIZE_DEF,
    parameter logic [31:0] RAM_BASE = RAM_BASE_DEF,
    parameter logic [31:0] RAM_SIZE = RAM_SIZE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] addr,
    output logic        out_valid,
    output logic [31:0] addr_translated,
    output logic        is_rom,
    output logic        is_ram,
    output logic        fault
);

    logic        rom_hit;
    logic        ram_hit;
    logic [31:0] rom_off;
    logic [31:0] ram_off;
    trans_t      res_d;
    trans_t      res_q;
    logic        valid_q;

    addr_region_match u_rom (
        .addr   (addr),
        .base   (ROM_BASE),
        .size   (ROM_SIZE),
        .hit    (rom_hit),
        .offset (rom_off)
    );

    addr_region_match u_ram (
        .addr   (addr),
        .base   (RAM_BASE),
        .size   (RAM_SIZE),
        .hit    (ram_hit),
        .offset (ram_off)
    );

    always_comb begin
        res_d = '{offset: '0, is_rom: 1'b0, is_ram: 1'b0, fault: 1'b1};
        if (rom_hit) begin
            res_d = '{offset: rom_off, is_rom: 1'b1,
                      is_ram: 1'b0, fault: 1'b0};
        end else if (ram_hit) begin
            res_d = '{offset: ram_off, is_rom: 1'b0,
                      is_ram: 1'b1, fault: 1'b0};
        end
    end

    // Result only loads on a valid input; idle cycles hold it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            res_q   <= '0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                res_q <= res_d;
            end
        end
    end

    assign out_valid       = valid_q;
    assign addr_translated = res_q.offset;
    assign is_rom          = res_q.is_rom;
    assign is_ram          = res_q.is_ram;
    assign fault           = res_q.fault;

endmodule

// File: tb/tb_addr_trans.sv
// Bench for addr_trans: directed vectors plus a per-cycle range model.
// Extra instances cover overlap priority, zero size and top-of-space.
module tb_addr_trans;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid;
    logic [31:0] addr;

    logic        out_valid;
    logic [31:0] addr_translated;
    logic        is_rom;
    logic        is_ram;
    logic        fault;

    logic        v2, rom2, ram2, f2;
    logic [31:0] t2;
    logic        v3, rom3, ram3, f3;
    logic [31:0] t3;

    int n_cmp = 0;
    int n_bad = 0;

    logic        m_valid = 1'b0;
    logic [31:0] m_off   = '0;
    logic        m_rom   = 1'b0;
    logic        m_ram   = 1'b0;
    logic        m_fault = 1'b0;

    always #5 clk = ~clk;

    addr_trans dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .addr            (addr),
        .out_valid       (out_valid),
        .addr_translated (addr_translated),
        .is_rom          (is_rom),
        .is_ram          (is_ram),
        .fault           (fault)
    );

    addr_trans #(
        .ROM_BASE (32'h0000_1000),
        .ROM_SIZE (32'h0000_1000),
        .RAM_BASE (32'h0000_0000),
        .RAM_SIZE (32'h0001_0000)
    ) dut_ovl (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .addr            (addr),
        .out_valid       (v2),
        .addr_translated (t2),
        .is_rom          (rom2),
        .is_ram          (ram2),
        .fault           (f2)
    );

    addr_trans #(
        .ROM_BASE (32'h0000_0000),
        .ROM_SIZE (32'h0000_0000),
        .RAM_BASE (32'hFFFF_F000),
        .RAM_SIZE (32'h0000_1000)
    ) dut_top (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .addr            (addr),
        .out_valid       (v3),
        .addr_translated (t3),
        .is_rom          (rom3),
        .is_ram          (ram3),
        .fault           (f3)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit range test on the default map.
    always @(posedge clk or posedge rst) begin
        longint unsigned a;
        if (rst) begin
            m_valid <= 1'b0;
            m_off   <= '0;
            m_rom   <= 1'b0;
            m_ram   <= 1'b0;
            m_fault <= 1'b0;
        end else begin
            m_valid <= in_valid;
            if (in_valid) begin
                a = 64'(addr);
                if (a < 64'h0010_0000) begin
                    m_off <= addr; m_rom <= 1'b1;
                    m_ram <= 1'b0; m_fault <= 1'b0;
                end else if (a >= 64'h0020_0000 && a < 64'h00A0_0000) begin
                    m_off <= 32'(a - 64'h0020_0000); m_rom <= 1'b0;
                    m_ram <= 1'b1; m_fault <= 1'b0;
                end else begin
                    m_off <= '0; m_rom <= 1'b0;
                    m_ram <= 1'b0; m_fault <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model.out_valid", 32'(out_valid), 32'(m_valid));
        chk("model.translated", addr_translated, m_off);
        chk("model.is_rom", 32'(is_rom), 32'(m_rom));
        chk("model.is_ram", 32'(is_ram), 32'(m_ram));
        chk("model.fault", 32'(fault), 32'(m_fault));
    end

    task automatic send(input logic [31:0] a, input logic er,
                        input logic em, input logic ef,
                        input logic [31:0] eo);
        in_valid = 1'b1;
        addr     = a;
        @(posedge clk);
        #1;
        chk("vec.out_valid", 32'(out_valid), 32'd1);
        chk("vec.is_rom", 32'(is_rom), 32'(er));
        chk("vec.is_ram", 32'(is_ram), 32'(em));
        chk("vec.fault", 32'(fault), 32'(ef));
        chk("vec.translated", addr_translated, eo);
    endtask

    task automatic chk_zero(input string name);
        chk({name, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({name, ".translated"}, addr_translated, 32'd0);
        chk({name, ".is_rom"}, 32'(is_rom), 32'd0);
        chk({name, ".is_ram"}, 32'(is_ram), 32'd0);
        chk({name, ".fault"}, 32'(fault), 32'd0);
    endtask

    initial begin
        in_valid = 1'b0;
        addr     = '0;
        rst      = 1'b1;
        #1;
        chk_zero("reset");
        #12;
        rst = 1'b0;

        send(32'h0000_0000, 1, 0, 0, 32'h0000_0000);
        send(32'h000F_FFFF, 1, 0, 0, 32'h000F_FFFF);
        send(32'h0000_0123, 1, 0, 0, 32'h0000_0123);
        send(32'h0010_0000, 0, 0, 1, 32'h0000_0000);
        send(32'h1234_5678, 0, 0, 1, 32'h0000_0000);
        send(32'h0020_0000, 0, 1, 0, 32'h0000_0000);
        send(32'h0020_0123, 0, 1, 0, 32'h0000_0123);
        send(32'h009F_FFFF, 0, 1, 0, 32'h007F_FFFF);
        send(32'h00A0_0000, 0, 0, 1, 32'h0000_0000);
        send(32'h00A0_0001, 0, 0, 1, 32'h0000_0000);
        send(32'h001F_FFFF, 0, 0, 1, 32'h0000_0000);

        send(32'h0000_1800, 1, 0, 0, 32'h0000_1800);
        chk("ovl.is_rom", 32'(rom2), 32'd1);
        chk("ovl.translated", t2, 32'h0000_0800);
        send(32'h0000_0800, 1, 0, 0, 32'h0000_0800);
        chk("ovl.is_ram", 32'(ram2), 32'd1);
        chk("ovl.translated_ram", t2, 32'h0000_0800);
        send(32'h0000_0000, 1, 0, 0, 32'h0000_0000);
        chk("zero_size.fault", 32'(f3), 32'd1);
        chk("zero_size.is_rom", 32'(rom3), 32'd0);
        send(32'hFFFF_FFFF, 0, 0, 1, 32'h0000_0000);
        chk("top.is_ram", 32'(ram3), 32'd1);
        chk("top.translated", t3, 32'h0000_0FFF);
        chk("top.out_valid", 32'(v3), 32'd1);

        send(32'h0040_0000, 0, 1, 0, 32'h0020_0000);
        in_valid = 1'b0;
        addr     = 32'h0000_0000;
        @(posedge clk);
        #1;
        chk("idle.out_valid", 32'(out_valid), 32'd0);
        chk("idle.is_ram", 32'(is_ram), 32'd1);
        chk("idle.translated", addr_translated, 32'h0020_0000);
        chk("idle.fault", 32'(fault), 32'd0);

        send(32'h0000_0300, 1, 0, 0, 32'h0000_0300);
        in_valid = 1'b1;
        addr     = 32'h0020_0005;
        #2;
        rst = 1'b1;
        #1;
        chk_zero("rst_async");
        @(posedge clk);
        #1;
        chk_zero("rst_hold");
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_zero("rst_drop");
        send(32'h0020_0040, 0, 1, 0, 32'h0000_0040);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("tail.out_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
